bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_pkg.sv | 13 +
 rtl/bram_rd_skid.sv | 46 ++++
 rtl/bram_stream_reader.sv | 145 ++++++++++++++
 tb/tb_bram_stream_reader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the BRAM burst-to-stream reader.
package bram_stream_pkg;

    // Depth of the read-data skid FIFO; the read issue logic is built around it.
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry skid FIFO holding BRAM read data plus its last-word flag.
// Head entry is presented combinationally and only moves on pop, so it
// stays stable while the consumer stalls.
import bram_stream_pkg::*;

module bram_rd_skid #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;

    // Pointers and occupancy; simultaneous push and pop leave cnt unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset: contents are only visible while cnt is nonzero.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data  = mem[rd_ptr];
    assign head_valid = (cnt != 2'd0);
    assign count      = cnt;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of consecutive BRAM words and streams them out as AXI-Stream.
// Optional feature: define BRAM_STREAM_READER_STATS_EN to add a 32-bit
// beat_count output counting stream handshakes.
import bram_stream_pkg::*;

module bram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  bram_rden,
    output logic                  bram_wren,
    output logic [STRB_WIDTH-1:0] bram_wrstrb,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
`ifdef BRAM_STREAM_READER_STATS_EN
    output logic                  done,
    output logic [31:0]           beat_count
`else
    output logic                  done
`endif
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   remain_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  done_q;

    logic [DATA_WIDTH:0]   head;
    logic                  head_valid;
    logic [1:0]            occ;
    logic                  pop;
    logic                  accept;
    logic                  last_rd;
    logic [2:0]            pending;
    logic                  rd_ok;

    assign pop     = head_valid & m_axis_tready;
    assign accept  = cmd_valid & cmd_ready;
    assign last_rd = (remain_q == LEN_ONE);

    // The slot popped this cycle is already free when the new read lands two
    // edges later, so it is credited back; this keeps one beat per cycle
    // while never letting occupancy exceed the FIFO depth.
    assign pending = {1'b0, occ} - {2'b0, pop} + {2'b0, inflight_q};
    assign rd_ok   = (pending < 3'(SKID_DEPTH));

    // Next state, read strobe and command handshake.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        bram_rden = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && cmd_len != '0) state_d = READ;
            end
            READ: begin
                if (rd_ok) begin
                    bram_rden = 1'b1;
                    if (last_rd) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head[DATA_WIDTH]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Address/count tracking, in-flight read tag and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q          <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            inflight_q      <= bram_rden;
            inflight_last_q <= bram_rden & last_rd;
            done_q          <= (accept && cmd_len == '0) || (pop && head[DATA_WIDTH]);
            if (accept && cmd_len != '0) begin
                addr_q   <= cmd_addr;
                remain_q <= cmd_len;
            end else if (bram_rden) begin
                addr_q   <= addr_q + ADDR_ONE;
                remain_q <= remain_q - LEN_ONE;
            end
        end
    end

    bram_rd_skid #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({inflight_last_q, bram_dout}),
        .pop       (pop),
        .head_data (head),
        .head_valid(head_valid),
        .count     (occ)
    );

    assign bram_addr     = addr_q;
    assign bram_wren     = 1'b0;
    assign bram_wrstrb   = '0;
    assign bram_din      = '0;
    assign m_axis_tvalid = head_valid;
    assign m_axis_tdata  = head_valid ? head[DATA_WIDTH-1:0] : '0;
    assign m_axis_tlast  = head_valid & head[DATA_WIDTH];
    assign done          = done_q;

`ifdef BRAM_STREAM_READER_STATS_EN
    // Free-running handshake counter, wraps naturally at 2**32.
    always_ff @(posedge clk) begin
        if (rst)      beat_count <= '0;
        else if (pop) beat_count <= beat_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: main instance (ADDR_WIDTH=8) plus a
// small ADDR_WIDTH=4 instance for the address wrap case.
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // main instance
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_addr = '0;
    logic [8:0]  cmd_len = '0;
    logic        bram_rden, bram_wren;
    logic [3:0]  bram_wrstrb;
    logic [7:0]  bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout = '0;
    logic [31:0] tdata;
    logic        tvalid, tlast, done;
    logic        tready = 1'b1;
`ifdef BRAM_STREAM_READER_STATS_EN
    logic [31:0] beat_count;
`endif

    // wrap instance
    logic        w_cmd_valid = 1'b0;
    logic        w_cmd_ready;
    logic [3:0]  w_cmd_addr = '0;
    logic [4:0]  w_cmd_len = '0;
    logic        w_rden, w_wren;
    logic [3:0]  w_wrstrb;
    logic [3:0]  w_addr;
    logic [31:0] w_din;
    logic [31:0] w_dout = '0;
    logic [31:0] w_tdata;
    logic        w_tvalid, w_tlast, w_done;
`ifdef BRAM_STREAM_READER_STATS_EN
    logic [31:0] w_beat_count;
`endif

    bram_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .bram_rden(bram_rden), .bram_wren(bram_wren), .bram_wrstrb(bram_wrstrb),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast),
`ifdef BRAM_STREAM_READER_STATS_EN
        .done(done), .beat_count(beat_count)
`else
        .done(done)
`endif
    );

    bram_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) u_wrap (
        .clk(clk), .rst(rst),
        .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready), .cmd_addr(w_cmd_addr), .cmd_len(w_cmd_len),
        .bram_rden(w_rden), .bram_wren(w_wren), .bram_wrstrb(w_wrstrb),
        .bram_addr(w_addr), .bram_din(w_din), .bram_dout(w_dout),
        .m_axis_tdata(w_tdata), .m_axis_tvalid(w_tvalid), .m_axis_tready(1'b1),
        .m_axis_tlast(w_tlast),
`ifdef BRAM_STREAM_READER_STATS_EN
        .done(w_done), .beat_count(w_beat_count)
`else
        .done(w_done)
`endif
    );

    // BRAM models: mem[i] = i, one-cycle read latency.
    always @(posedge clk) if (bram_rden) bram_dout <= 32'(bram_addr);
    always @(posedge clk) if (w_rden)    w_dout    <= 32'(w_addr);

    int nvec = 0;
    int errs = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: beat capture, done timing, stall stability and read-issue safety.
    logic [32:0] q [$];
    logic [32:0] wq [$];
    int done_cnt = 0, done_cyc = 0, last_cyc = 0, rden_cnt = 0, w_done_cnt = 0;
    int m_occ = 0, m_infl = 0;
    logic prev_stall = 1'b0;
    logic [32:0] prev_beat = '0;
    always @(negedge clk) begin
        if (rst) begin
            m_occ = 0;
            m_infl = 0;
            prev_stall = 1'b0;
        end else begin
            int pop;
            pop = (tvalid && tready) ? 1 : 0;
            if (prev_stall) begin
                chk("stall_tvalid", tvalid, 1'b1);
                chk("stall_hold", {tlast, tdata}, prev_beat);
            end
            if (bram_rden) begin
                rden_cnt++;
                chk("rden_room", (m_occ - pop + m_infl) < 2, 1'b1);
            end
            if (pop != 0) q.push_back({tlast, tdata});
            if (pop != 0 && tlast) last_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            m_occ = m_occ - pop + m_infl;
            m_infl = bram_rden ? 1 : 0;
            prev_stall = tvalid && !tready;
            prev_beat = {tlast, tdata};
            if (w_tvalid) wq.push_back({w_tlast, w_tdata});
            if (w_done) w_done_cnt++;
        end
    end

    task automatic send_cmd(input logic [7:0] a, input logic [8:0] l);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge clk);
        chk(tag, done_cnt > d0, 1'b1);
        @(negedge clk);
    endtask

    task automatic check_beats(input string tag, input logic [31:0] base, input int n);
        chk({tag, "_count"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            chk({tag, "_data"}, q[i][31:0], base + 32'(i));
            chk({tag, "_last"}, q[i][32], (i == n - 1));
        end
    endtask

    initial begin
        int d0, rc0;
        int wexp[4] = '{14, 15, 0, 1};

        // reset values
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rden", bram_rden, 1'b0);
        chk("rst_addr", bram_addr, 8'h00);
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_tlast", tlast, 1'b0);
        chk("rst_tdata", tdata, 32'h0);
        chk("rst_done", done, 1'b0);
        chk("write_side_zero", {bram_wren, bram_wrstrb, bram_din}, '0);

        // basic burst, latency and done timing
        q.delete(); d0 = done_cnt;
        send_cmd(8'h10, 9'd4);
        @(negedge clk); chk("lat_c1_tvalid", tvalid, 1'b0);
        @(negedge clk); chk("lat_c2_tvalid", tvalid, 1'b0);
        @(negedge clk); chk("lat_c3_tvalid", tvalid, 1'b1);
        chk("lat_c3_tdata", tdata, 32'h10);
        wait_done("burst_done", d0);
        check_beats("burst", 32'h10, 4);
        chk("burst_done_timing", done_cyc, last_cyc + 1);
        chk("burst_done_once", done_cnt, d0 + 1);

        // backpressure, tready toggling 1,0,1,0...
        q.delete(); d0 = done_cnt;
        send_cmd(8'h20, 9'd8);
        for (int i = 0; i < 200 && done_cnt == d0; i++) begin
            @(posedge clk); #1 tready = ~tready;
        end
        chk("bp_done", done_cnt > d0, 1'b1);
        @(posedge clk); #1 tready = 1'b1;
        @(negedge clk);
        check_beats("bp", 32'h20, 8);

        // zero length
        q.delete(); d0 = done_cnt; rc0 = rden_cnt;
        send_cmd(8'h30, 9'd0);
        @(negedge clk);
        chk("zl_done", done, 1'b1);
        chk("zl_cmd_ready", cmd_ready, 1'b1);
        chk("zl_tvalid", tvalid, 1'b0);
        @(negedge clk);
        chk("zl_done_drop", done, 1'b0);
        repeat (3) @(negedge clk);
        chk("zl_no_rden", rden_cnt, rc0);
        chk("zl_no_beats", q.size(), 0);
        chk("zl_done_once", done_cnt, d0 + 1);

        // reset mid-burst, then a fresh burst
        q.delete(); d0 = done_cnt;
        send_cmd(8'h40, 9'd16);
        for (int i = 0; i < 100 && q.size() < 5; i++) @(negedge clk);
        chk("mid_reached5", q.size() >= 5, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_tvalid", tvalid, 1'b0);
        chk("mid_cmd_ready", cmd_ready, 1'b1);
        repeat (5) @(negedge clk);
        chk("mid_tvalid_late", tvalid, 1'b0);
        chk("mid_no_done", done_cnt, d0);
        q.delete(); d0 = done_cnt;
        send_cmd(8'h50, 9'd2);
        wait_done("post_rst_done", d0);
        check_beats("post_rst", 32'h50, 2);

        // address wrap on the 4-bit instance
        @(posedge clk); #1;
        w_cmd_valid = 1'b1; w_cmd_addr = 4'hE; w_cmd_len = 5'd4;
        @(posedge clk); #1 w_cmd_valid = 1'b0;
        for (int i = 0; i < 100 && w_done_cnt == 0; i++) @(negedge clk);
        chk("wrap_done", w_done_cnt, 1);
        chk("wrap_count", wq.size(), 4);
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            chk("wrap_data", wq[i][31:0], 32'(wexp[i]));
            chk("wrap_last", wq[i][32], (i == 3));
        end

`ifdef BRAM_STREAM_READER_STATS_EN
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int b = 0; b < 3; b++) begin
            d0 = done_cnt;
            send_cmd(8'h60, 9'd3);
            wait_done("stats_done", d0);
        end
        chk("stats_count", beat_count, 32'd9);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("stats_rst", beat_count, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
